// File: rtl/voice_allocator_pkg.sv
// Shared defaults and helpers for the voice allocator slice.
// Note/duration/voice defaults match song_reader and chord_player.
package voice_allocator_pkg;

    localparam int DEF_NUM_VOICES = 3;
    localparam int DEF_NOTE_W     = 6;
    localparam int DEF_DUR_W      = 6;
    localparam int DEF_STEAL      = 1;

    localparam logic [7:0] STEAL_COUNT_MAX = 8'hFF;

    // Width needed to hold a voice index or an LRU rank; never below one bit.
    function automatic int rank_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Request handshake and per-voice load/done bus between a note source,
// the allocator and chord_player.
interface voice_allocator_if #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6
);
    logic                         flush;
    logic                         req_valid;
    logic [NOTE_W-1:0]            req_note;
    logic [DUR_W-1:0]             req_duration;
    logic                         req_ready;
    logic [NUM_VOICES*NOTE_W-1:0] note_out;
    logic [NUM_VOICES*DUR_W-1:0]  duration_out;
    logic [NUM_VOICES-1:0]        load_new_note;
    logic [NUM_VOICES-1:0]        done_with_note;
    logic [NUM_VOICES-1:0]        busy_voices;
    logic [7:0]                   steal_count;

    modport master (
        output flush, req_valid, req_note, req_duration, done_with_note,
        input  req_ready, note_out, duration_out, load_new_note, busy_voices, steal_count
    );

    modport slave (
        input  flush, req_valid, req_note, req_duration, done_with_note,
        output req_ready, note_out, duration_out, load_new_note, busy_voices, steal_count
    );
endinterface

// File: rtl/voice_allocator_lru_rank_tracker.sv
// LRU rank vector: rank 0 is the most recently loaded voice, NUM_VOICES-1 the oldest.
// Ranks are always a permutation of 0..NUM_VOICES-1.
module lru_rank_tracker
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int RANK_W     = rank_width(NUM_VOICES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [RANK_W-1:0] load_idx,
    output logic [RANK_W-1:0] oldest_idx
);

    logic [RANK_W-1:0] rank_reg [NUM_VOICES];
    logic [RANK_W-1:0] load_rank;

    assign load_rank = rank_reg[load_idx];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_rank
            // Voices more recent than the loaded one age by one; the loaded voice becomes newest.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    rank_reg[gi] <= RANK_W'(gi);
                end else if (load_valid) begin
                    if (load_idx == RANK_W'(gi)) begin
                        rank_reg[gi] <= '0;
                    end else if (rank_reg[gi] < load_rank) begin
                        rank_reg[gi] <= rank_reg[gi] + 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        oldest_idx = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (rank_reg[v] == RANK_W'(NUM_VOICES - 1)) begin
                oldest_idx = RANK_W'(v);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Routes note requests onto chord_player voices: lowest free voice first,
// otherwise steal the least recently loaded voice (or stall when STEAL=0).
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int DUR_W      = DEF_DUR_W,
    parameter int STEAL      = DEF_STEAL
) (
    input  logic            clk,
    input  logic            reset,
    voice_allocator_if.slave bus
);

    localparam int RANK_W = rank_width(NUM_VOICES);

    logic [NUM_VOICES-1:0]        busy_reg;
    logic [NUM_VOICES-1:0]        busy_next;
    logic [NUM_VOICES-1:0]        load_reg;
    logic [NUM_VOICES-1:0]        load_onehot;
    logic [NUM_VOICES*NOTE_W-1:0] note_reg;
    logic [NUM_VOICES*DUR_W-1:0]  dur_reg;
    logic [7:0]                   steal_cnt_reg;

    logic              free_any;
    logic [RANK_W-1:0] free_idx;
    logic [RANK_W-1:0] oldest_idx;
    logic [RANK_W-1:0] load_idx;
    logic              accept;
    logic              steal;

    // Priority encoder: scanning downward leaves the lowest free index.
    always_comb begin
        free_idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!busy_reg[v]) begin
                free_idx = RANK_W'(v);
            end
        end
    end

    assign free_any      = |(~busy_reg);
    assign bus.req_ready = reset && !bus.flush && (free_any || (STEAL != 0));
    assign accept        = bus.req_valid && bus.req_ready;
    assign steal         = accept && !free_any;
    assign load_idx      = free_any ? free_idx : oldest_idx;

    lru_rank_tracker #(
        .NUM_VOICES (NUM_VOICES),
        .RANK_W     (RANK_W)
    ) u_rank (
        .clk        (clk),
        .reset      (reset),
        .load_valid (accept),
        .load_idx   (load_idx),
        .oldest_idx (oldest_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            assign load_onehot[gi] = accept && (load_idx == RANK_W'(gi));

            always_ff @(posedge clk) begin
                if (!reset) begin
                    note_reg[gi*NOTE_W +: NOTE_W] <= '0;
                    dur_reg[gi*DUR_W +: DUR_W]    <= '0;
                end else if (load_onehot[gi]) begin
                    note_reg[gi*NOTE_W +: NOTE_W] <= bus.req_note;
                    dur_reg[gi*DUR_W +: DUR_W]    <= bus.req_duration;
                end
            end
        end
    endgenerate

    // A load on the same voice as a done pulse wins because the OR comes last.
    always_comb begin
        if (bus.flush) begin
            busy_next = '0;
        end else begin
            busy_next = (busy_reg & ~bus.done_with_note) | load_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_reg      <= '0;
            load_reg      <= '0;
            steal_cnt_reg <= '0;
        end else begin
            busy_reg <= busy_next;
            load_reg <= load_onehot;
            if (steal && (steal_cnt_reg != STEAL_COUNT_MAX)) begin
                steal_cnt_reg <= steal_cnt_reg + 8'd1;
            end
        end
    end

    assign bus.note_out      = note_reg;
    assign bus.duration_out  = dur_reg;
    assign bus.load_new_note = load_reg;
    assign bus.busy_voices   = busy_reg;
    assign bus.steal_count   = steal_cnt_reg;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench: a vector table on a stealing allocator, then hand sequences
// for the stalling (STEAL=0) build and steal-counter saturation.
module tb_voice_allocator;
    localparam int NV = 3;
    localparam int NW = 6;
    localparam int DW = 6;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    voice_allocator_if #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) bus1 ();
    voice_allocator_if #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) bus2 ();

    voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW), .STEAL(1)) dut_steal (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW), .STEAL(0)) dut_stall (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        valid;
        logic [5:0]  note;
        logic [5:0]  dur;
        logic [2:0]  done;
        logic        exp_ready;
        logic [2:0]  exp_load;
        logic [2:0]  exp_busy;
        logic [17:0] exp_note;
        logic [17:0] exp_dur;
        logic [7:0]  exp_steal;
    } vec_t;

    vec_t vecs [17];

    function automatic logic [17:0] pk(input logic [5:0] v2, input logic [5:0] v1, input logic [5:0] v0);
        return {v2, v1, v0};
    endfunction

    function automatic vec_t mk(input logic rst, input logic flush, input logic valid,
                                input logic [5:0] note, input logic [5:0] dur, input logic [2:0] done,
                                input logic rdy, input logic [2:0] ld, input logic [2:0] busy,
                                input logic [17:0] nout, input logic [17:0] dout, input logic [7:0] stl);
        vec_t v;
        v.rst = rst; v.flush = flush; v.valid = valid; v.note = note; v.dur = dur; v.done = done;
        v.exp_ready = rdy; v.exp_load = ld; v.exp_busy = busy;
        v.exp_note = nout; v.exp_dur = dout; v.exp_steal = stl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle1();
        bus1.flush = 1'b0; bus1.req_valid = 1'b0; bus1.req_note = '0;
        bus1.req_duration = '0; bus1.done_with_note = '0;
    endtask

    task automatic idle2();
        bus2.flush = 1'b0; bus2.req_valid = 1'b0; bus2.req_note = '0;
        bus2.req_duration = '0; bus2.done_with_note = '0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        idle1();
        idle2();

        vecs[0]  = mk(0,0,0, 0,0,3'b000, 0,3'b000,3'b000, 18'd0, 18'd0, 8'd0);
        vecs[1]  = mk(1,0,1,10,1,3'b000, 1,3'b000,3'b000, 18'd0, 18'd0, 8'd0);
        vecs[2]  = mk(1,0,1,11,2,3'b000, 1,3'b001,3'b001, pk(0,0,10),  pk(0,0,1), 8'd0);
        vecs[3]  = mk(1,0,1,12,3,3'b000, 1,3'b010,3'b011, pk(0,11,10), pk(0,2,1), 8'd0);
        vecs[4]  = mk(1,0,1,20,4,3'b000, 1,3'b100,3'b111, pk(12,11,10),pk(3,2,1), 8'd0);
        vecs[5]  = mk(1,0,1,21,5,3'b000, 1,3'b001,3'b111, pk(12,11,20),pk(3,2,4), 8'd1);
        vecs[6]  = mk(1,0,0, 0,0,3'b010, 1,3'b010,3'b111, pk(12,21,20),pk(3,5,4), 8'd2);
        vecs[7]  = mk(1,0,1,30,6,3'b000, 1,3'b000,3'b101, pk(12,21,20),pk(3,5,4), 8'd2);
        vecs[8]  = mk(1,0,1,40,7,3'b100, 1,3'b010,3'b111, pk(12,30,20),pk(3,6,4), 8'd2);
        vecs[9]  = mk(1,1,1,50,8,3'b001, 0,3'b100,3'b111, pk(40,30,20),pk(7,6,4), 8'd3);
        vecs[10] = mk(1,0,0, 0,0,3'b000, 1,3'b000,3'b000, pk(40,30,20),pk(7,6,4), 8'd3);
        vecs[11] = mk(1,0,1,50,8,3'b000, 1,3'b000,3'b000, pk(40,30,20),pk(7,6,4), 8'd3);
        vecs[12] = mk(1,1,0, 0,0,3'b000, 0,3'b001,3'b001, pk(40,30,50),pk(7,6,8), 8'd3);
        vecs[13] = mk(1,0,0, 0,0,3'b001, 1,3'b000,3'b000, pk(40,30,50),pk(7,6,8), 8'd3);
        vecs[14] = mk(1,0,1,60,9,3'b000, 1,3'b000,3'b000, pk(40,30,50),pk(7,6,8), 8'd3);
        vecs[15] = mk(0,0,1, 0,0,3'b000, 0,3'b001,3'b001, pk(40,30,60),pk(7,6,9), 8'd3);
        vecs[16] = mk(1,0,0, 0,0,3'b000, 1,3'b000,3'b000, 18'd0, 18'd0, 8'd0);

        repeat (2) @(posedge clk);

        // Each vector drives one cycle; expectations are the state left by earlier edges.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            reset                = vecs[i].rst;
            bus1.flush           = vecs[i].flush;
            bus1.req_valid       = vecs[i].valid;
            bus1.req_note        = vecs[i].note;
            bus1.req_duration    = vecs[i].dur;
            bus1.done_with_note  = vecs[i].done;
            #1;
            $display("vec %0d: rst=%0b flush=%0b valid=%0b note=%0d done=%b -> ready=%0b load=%b busy=%b steals=%0d",
                     i, vecs[i].rst, vecs[i].flush, vecs[i].valid, vecs[i].note, vecs[i].done,
                     bus1.req_ready, bus1.load_new_note, bus1.busy_voices, bus1.steal_count);
            check($sformatf("v%0d req_ready", i),   32'(bus1.req_ready),     32'(vecs[i].exp_ready));
            check($sformatf("v%0d load", i),        32'(bus1.load_new_note), 32'(vecs[i].exp_load));
            check($sformatf("v%0d busy", i),        32'(bus1.busy_voices),   32'(vecs[i].exp_busy));
            check($sformatf("v%0d note_out", i),    32'(bus1.note_out),      32'(vecs[i].exp_note));
            check($sformatf("v%0d duration", i),    32'(bus1.duration_out),  32'(vecs[i].exp_dur));
            check($sformatf("v%0d steal_count", i), 32'(bus1.steal_count),   32'(vecs[i].exp_steal));
        end
        @(negedge clk);
        idle1();

        // STEAL=0: fill all voices, then a held request must stall until a done frees voice 1.
        for (int i = 0; i < 3; i++) begin
            bus2.req_valid = 1'b1;
            bus2.req_note = 6'(i + 1);
            bus2.req_duration = 6'(i + 1);
            @(negedge clk);
        end
        bus2.req_note = 6'd33;
        bus2.req_duration = 6'd44;
        #1;
        $display("stall: busy=%b ready=%0b", bus2.busy_voices, bus2.req_ready);
        check("stall busy full", 32'(bus2.busy_voices), 32'h7);
        check("stall ready low", 32'(bus2.req_ready), 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            $display("stall hold %0d: ready=%0b load=%b", i, bus2.req_ready, bus2.load_new_note);
            check("stall hold ready", 32'(bus2.req_ready), 32'h0);
            check("stall hold no strobe", 32'(bus2.load_new_note), 32'h0);
        end
        @(negedge clk);
        bus2.done_with_note = 3'b010;
        #1;
        check("stall ready during done", 32'(bus2.req_ready), 32'h0);
        @(negedge clk);
        bus2.done_with_note = 3'b000;
        #1;
        $display("stall freed: busy=%b ready=%0b", bus2.busy_voices, bus2.req_ready);
        check("stall freed busy", 32'(bus2.busy_voices), 32'h5);
        check("stall freed ready", 32'(bus2.req_ready), 32'h1);
        @(negedge clk);
        idle2();
        #1;
        $display("stall accept: load=%b note1=%0d dur1=%0d", bus2.load_new_note,
                 bus2.note_out[NW +: NW], bus2.duration_out[DW +: DW]);
        check("stall strobe voice1", 32'(bus2.load_new_note), 32'h2);
        check("stall note voice1", 32'(bus2.note_out[NW +: NW]), 32'd33);
        check("stall dur voice1", 32'(bus2.duration_out[DW +: DW]), 32'd44);
        check("stall busy refilled", 32'(bus2.busy_voices), 32'h7);
        check("stall no steals", 32'(bus2.steal_count), 32'h0);

        // Saturation: 3 fills then 260 steals must stop the counter at 255.
        bus1.req_valid = 1'b1;
        bus1.req_note = 6'd5;
        bus1.req_duration = 6'd5;
        repeat (263) @(negedge clk);
        idle1();
        #1;
        $display("saturate: steal_count=%0d", bus1.steal_count);
        check("steal_count saturates", 32'(bus1.steal_count), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
